// File: rtl/morse_key_sequencer.sv
// Key-line front end for the morse decoder: times presses and gaps and emits one-hot
// symbol/space pulses with post-space holdoff and a single-entry pending slot.
module morse_key_sequencer #(
  parameter int UNIT  = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic key_in,
  output logic dot_inp,
  output logic dash_inp,
  output logic char_space_inp,
  output logic word_space_inp,
  output logic sym_err,
  output logic overrun,
  output logic busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_GAP     = 3'd2,
    ST_CHARGAP = 3'd3,
    ST_STUCK   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DASH_MIN  = CNT_W'(2 * UNIT);
  localparam logic [CNT_W-1:0] CHAR_GAP  = CNT_W'(2 * UNIT);
  localparam logic [CNT_W-1:0] WORD_GAP  = CNT_W'(5 * UNIT);
  localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(8 * UNIT);

  logic             sync_meta_r, key_s_r;
  state_t           state_r, state_n;
  logic [CNT_W-1:0] press_cnt_r, press_cnt_n, gap_cnt_r, gap_cnt_n;
  logic [2:0]       holdoff_r, holdoff_n;
  logic             pend_valid_r, pend_valid_n, pend_dash_r, pend_dash_n;
  logic             dot_r, dash_r, char_r, word_r, err_r, overrun_r, busy_r;
  logic             dot_n, dash_n, char_n, word_n, err_n, overrun_n, busy_n;
  logic             classify_s, sym_dash_s, release_s;

  // Two-flop synchroniser; keeps running while en=0 so a held key is seen on re-enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 1'b0;
      key_s_r     <= 1'b0;
    end else begin
      sync_meta_r <= key_in;
      key_s_r     <= sync_meta_r;
    end
  end

  // Next-state, counter, holdoff, pending-slot and output-pulse logic.
  always_comb begin
    state_n      = state_r;
    press_cnt_n  = press_cnt_r;
    gap_cnt_n    = gap_cnt_r;
    pend_valid_n = pend_valid_r;
    pend_dash_n  = pend_dash_r;
    dot_n        = 1'b0;
    dash_n       = 1'b0;
    char_n       = 1'b0;
    word_n       = 1'b0;
    err_n        = 1'b0;
    overrun_n    = 1'b0;
    classify_s   = 1'b0;
    sym_dash_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (key_s_r) begin
          state_n     = ST_PRESS;
          press_cnt_n = ONE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (key_s_r) begin
          if (press_cnt_r >= STUCK_LIM - ONE) begin
            press_cnt_n = STUCK_LIM;
            err_n       = 1'b1;
            state_n     = ST_STUCK;
          end else begin
            press_cnt_n = press_cnt_r + ONE;
          end
        end else begin
          classify_s = 1'b1;
          sym_dash_s = (press_cnt_r >= DASH_MIN);
          state_n    = ST_GAP;
          gap_cnt_n  = ONE;
        end
      end
      ST_GAP: begin
        if (key_s_r) begin
          state_n     = ST_PRESS;
          press_cnt_n = ONE;
        end else if (gap_cnt_r >= CHAR_GAP - ONE) begin
          gap_cnt_n = CHAR_GAP;
          char_n    = 1'b1;
          state_n   = ST_CHARGAP;
        end else begin
          gap_cnt_n = gap_cnt_r + ONE;
        end
      end
      ST_CHARGAP: begin
        if (key_s_r) begin
          state_n     = ST_PRESS;
          press_cnt_n = ONE;
        end else if (gap_cnt_r >= WORD_GAP - ONE) begin
          gap_cnt_n = WORD_GAP;
          word_n    = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt_r + ONE;
        end
      end
      ST_STUCK: begin
        if (!key_s_r) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_STUCK;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (word_n) begin
      holdoff_n = 3'd7;
    end else if (char_n) begin
      holdoff_n = 3'd3;
    end else if (holdoff_r != 3'd0) begin
      holdoff_n = holdoff_r - 3'd1;
    end else begin
      holdoff_n = 3'd0;
    end

    // Release and immediate output are exclusive: release needs a full slot, immediate an empty one.
    release_s = pend_valid_r && (holdoff_r == 3'd0);
    if (release_s) begin
      pend_valid_n = 1'b0;
      dot_n        = !pend_dash_r;
      dash_n       = pend_dash_r;
    end else begin
      pend_valid_n = pend_valid_r;
    end

    if (classify_s) begin
      if (pend_valid_r) begin
        overrun_n = 1'b1;
      end else if (holdoff_r != 3'd0) begin
        pend_valid_n = 1'b1;
        pend_dash_n  = sym_dash_s;
      end else begin
        dot_n  = !sym_dash_s;
        dash_n = sym_dash_s;
      end
    end else begin
      overrun_n = 1'b0;
    end

    busy_n = (state_n != ST_IDLE) || pend_valid_n || (holdoff_n != 3'd0);
  end

  // State and output registers; en=0 flushes everything except the synchroniser.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_r      <= ST_IDLE;
      press_cnt_r  <= '0;
      gap_cnt_r    <= '0;
      holdoff_r    <= 3'd0;
      pend_valid_r <= 1'b0;
      pend_dash_r  <= 1'b0;
      dot_r        <= 1'b0;
      dash_r       <= 1'b0;
      char_r       <= 1'b0;
      word_r       <= 1'b0;
      err_r        <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      press_cnt_r  <= press_cnt_n;
      gap_cnt_r    <= gap_cnt_n;
      holdoff_r    <= holdoff_n;
      pend_valid_r <= pend_valid_n;
      pend_dash_r  <= pend_dash_n;
      dot_r        <= dot_n;
      dash_r       <= dash_n;
      char_r       <= char_n;
      word_r       <= word_n;
      err_r        <= err_n;
      overrun_r    <= overrun_n;
      busy_r       <= busy_n;
    end
  end

  assign dot_inp        = dot_r;
  assign dash_inp       = dash_r;
  assign char_space_inp = char_r;
  assign word_space_inp = word_r;
  assign sym_err        = err_r;
  assign overrun        = overrun_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer (UNIT=4): pulse timing, spacing, holdoff,
// overrun, stuck key, reset and enable flush.
module tb_morse_key_sequencer;

  logic clk = 1'b0;
  logic rst, en, key_in;
  logic dot_inp, dash_inp, char_space_inp, word_space_inp, sym_err, overrun, busy;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int c;
  int n_dot, n_dash, n_char, n_word, n_err, n_ovr;
  int last_dot, last_dash, last_char, last_word, last_err, last_ovr;
  int onehot_err = 0;
  int contract_err = 0;
  int last_sp_cyc = -100;
  int last_sp_len = 0;

  morse_key_sequencer #(.UNIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .key_in(key_in),
    .dot_inp(dot_inp), .dash_inp(dash_inp),
    .char_space_inp(char_space_inp), .word_space_inp(word_space_inp),
    .sym_err(sym_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder plus independent one-hot and holdoff-contract watch.
  always @(negedge clk) begin
    if (dot_inp)        begin n_dot++;  last_dot  = cyc; end
    if (dash_inp)       begin n_dash++; last_dash = cyc; end
    if (char_space_inp) begin n_char++; last_char = cyc; end
    if (word_space_inp) begin n_word++; last_word = cyc; end
    if (sym_err)        begin n_err++;  last_err  = cyc; end
    if (overrun)        begin n_ovr++;  last_ovr  = cyc; end
    if ($countones({dot_inp, dash_inp, char_space_inp, word_space_inp}) > 1) onehot_err++;
    if ((dot_inp || dash_inp || char_space_inp || word_space_inp) &&
        (cyc - last_sp_cyc) <= last_sp_len) contract_err++;
    if (char_space_inp) begin last_sp_cyc = cyc; last_sp_len = 3; end
    if (word_space_inp) begin last_sp_cyc = cyc; last_sp_len = 7; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    key_in = 1'b1;
    tick(hi);
    key_in = 1'b0;
    tick(lo);
  endtask

  task automatic clear_counts();
    n_dot = 0; n_dash = 0; n_char = 0; n_word = 0; n_err = 0; n_ovr = 0;
    last_dot = -1; last_dash = -1; last_char = -1; last_word = -1; last_err = -1; last_ovr = -1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; key_in = 1'b0;
    tick(3);
    cmp_cnt++;
    if ({dot_inp, dash_inp, char_space_inp, word_space_inp, sym_err, overrun, busy} !== 7'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {dot_inp, dash_inp, char_space_inp, word_space_inp, sym_err, overrun, busy});
    end
    rst = 1'b0;
    tick(2);
    clear_counts();
  endtask

  task automatic test_dot_spacing();
    clear_counts();
    c = cyc;
    press(3, 40);
    chk("dot_count", n_dot, 1);
    chk("dot_cycle", last_dot - c, 6);
    chk("dot_no_dash", n_dash, 0);
    chk("char_count", n_char, 1);
    chk("char_cycle", last_char - c, 13);
    chk("word_count", n_word, 1);
    chk("word_cycle", last_word - c, 25);
    chk("idle_busy", busy, 0);
  endtask

  task automatic test_dash();
    clear_counts();
    c = cyc;
    press(8, 40);
    chk("dash_count", n_dash, 1);
    chk("dash_cycle", last_dash - c, 11);
    chk("dash_no_dot", n_dot, 0);
    clear_counts();
    c = cyc;
    press(7, 40);
    chk("boundary7_dot", n_dot, 1);
    chk("boundary7_no_dash", n_dash, 0);
  endtask

  task automatic test_char_holdoff();
    clear_counts();
    c = cyc;
    press(3, 9);
    press(1, 40);
    chk("hold_dot_count", n_dot, 2);
    chk("hold_dot_cycle", last_dot - c, 17);
    chk("hold_char_count", n_char, 2);
    chk("hold_no_overrun", n_ovr, 0);
  endtask

  task automatic test_overrun();
    clear_counts();
    c = cyc;
    press(3, 21);
    press(1, 1);
    press(1, 40);
    chk("ovr_dot_count", n_dot, 2);
    chk("ovr_dot_cycle", last_dot - c, 33);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_cycle", last_ovr - c, 30);
  endtask

  task automatic test_stuck();
    clear_counts();
    c = cyc;
    key_in = 1'b1;
    tick(38);
    chk("stuck_busy", busy, 1);
    tick(2);
    key_in = 1'b0;
    tick(10);
    chk("stuck_err_count", n_err, 1);
    chk("stuck_err_cycle", last_err - c, 34);
    chk("stuck_no_sym", n_dot + n_dash, 0);
    chk("stuck_no_space", n_char + n_word, 0);
    chk("stuck_busy_drop", busy, 0);
  endtask

  task automatic test_reset_mid_press();
    clear_counts();
    key_in = 1'b1;
    tick(7);
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b1;
    key_in = 1'b0;
    tick(1);
    chk("rstmid_outputs", {26'd0, dot_inp, dash_inp, char_space_inp, word_space_inp, sym_err, overrun}, 0);
    chk("rstmid_busy", busy, 0);
    tick(2);
    rst = 1'b0;
    tick(40);
    chk("rstmid_no_pulses", n_dot + n_dash + n_char + n_word + n_err, 0);
  endtask

  task automatic test_enable_flush();
    clear_counts();
    c = cyc;
    key_in = 1'b1;
    tick(5);
    en = 1'b0;
    tick(1);
    chk("en0_busy", busy, 0);
    tick(2);
    en = 1'b1;
    tick(1);
    chk("en1_busy", busy, 1);
    key_in = 1'b0;
    tick(40);
    chk("en_dot_count", n_dot, 1);
    chk("en_dot_cycle", last_dot - c, 12);
    chk("en_no_dash", n_dash, 0);
  endtask

  task automatic test_contract();
    chk("onehot_violations", onehot_err, 0);
    chk("holdoff_violations", contract_err, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; key_in = 1'b0;
    clear_counts();
    test_reset();
    test_dot_spacing();
    test_dash();
    test_char_holdoff();
    test_overrun();
    test_stuck();
    test_reset_mid_press();
    test_enable_flush();
    test_contract();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
